// File: rtl/cpu_datapath_if.sv
// ============================================================================
// Module      : cpu_datapath_if
// Description : Control-strobe / observation bundle for the single-bus datapath.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cpu_datapath_if;
  logic [31:0] Mdatain;
  logic        Read;
  logic        MDRin, R1in, R2in, R3in, IRin, Yin, HIin;
  logic        PCout, MDRout, R2out, R3out, Zlowout, ZHighout;
  logic        AND;
  logic [31:0] BusMuxOut;
  logic [31:0] R1_q, R2_q, R3_q, IR_q, HI_q;

  modport master (
    output Mdatain, Read,
    output MDRin, R1in, R2in, R3in, IRin, Yin, HIin,
    output PCout, MDRout, R2out, R3out, Zlowout, ZHighout,
    output AND,
    input  BusMuxOut, R1_q, R2_q, R3_q, IR_q, HI_q
  );

  modport slave (
    input  Mdatain, Read,
    input  MDRin, R1in, R2in, R3in, IRin, Yin, HIin,
    input  PCout, MDRout, R2out, R3out, Zlowout, ZHighout,
    input  AND,
    output BusMuxOut, R1_q, R2_q, R3_q, IR_q, HI_q
  );
endinterface

`default_nettype wire

// File: rtl/cpu_datapath.sv
// ============================================================================
// Module      : cpu_datapath
// Description : Single-bus 32-bit datapath (R1-R3, PC, IR, MDR, Y, Z, HI, ALU).
//               Define DATAPATH_MUL_EN to build the signed 32x32->64 multiply.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_datapath (
  input  wire             clock,
  input  wire             clear,
  cpu_datapath_if.slave   dp
);

  localparam logic [3:0] c_op_and = 4'h0;
  localparam logic [3:0] c_op_or  = 4'h1;
  localparam logic [3:0] c_op_add = 4'h2;
  localparam logic [3:0] c_op_sub = 4'h3;
  localparam logic [3:0] c_op_mul = 4'h4;
  localparam logic [3:0] c_op_shr = 4'h5;
  localparam logic [3:0] c_op_shl = 4'h6;
  localparam logic [3:0] c_op_sra = 4'h7;

  logic [31:0] pc_q, mdr_q, r1_q, r2_q, r3_q, ir_q, y_q, hi_q;
  logic [63:0] z_q;
  logic [31:0] w_bus;
  logic [63:0] w_alu;
  logic [4:0]  w_shamt;

  // Fixed-priority source select; an idle bus reads as zero.
  always_comb begin
    w_bus = '0;
    if (dp.PCout)         w_bus = pc_q;
    else if (dp.MDRout)   w_bus = mdr_q;
    else if (dp.R2out)    w_bus = r2_q;
    else if (dp.R3out)    w_bus = r3_q;
    else if (dp.Zlowout)  w_bus = z_q[31:0];
    else if (dp.ZHighout) w_bus = z_q[63:32];
  end

  assign w_shamt = w_bus[4:0];

`ifdef DATAPATH_MUL_EN
  logic [63:0] w_mul;
  assign w_mul = 64'($signed({{32{y_q[31]}}, y_q}) * $signed({{32{w_bus[31]}}, w_bus}));
`endif

  always_comb begin
    w_alu = {32'b0, y_q & w_bus};
    case (ir_q[3:0])
      c_op_and: w_alu = {32'b0, y_q & w_bus};
      c_op_or:  w_alu = {32'b0, y_q | w_bus};
      c_op_add: w_alu = {32'b0, y_q + w_bus};
      c_op_sub: w_alu = {32'b0, y_q - w_bus};
`ifdef DATAPATH_MUL_EN
      c_op_mul: w_alu = w_mul;
`else
      c_op_mul: w_alu = {32'b0, y_q & w_bus};
`endif
      c_op_shr: w_alu = {32'b0, y_q >> w_shamt};
      c_op_shl: w_alu = {32'b0, y_q << w_shamt};
      c_op_sra: w_alu = {32'b0, 32'($signed(y_q) >>> w_shamt)};
      default:  w_alu = {32'b0, y_q & w_bus};
    endcase
  end

  // PC has no load path: it is only ever cleared and then holds.
  always_ff @(posedge clock) begin
    if (clear) begin
      pc_q  <= '0;
      mdr_q <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      ir_q  <= '0;
      y_q   <= '0;
      hi_q  <= '0;
      z_q   <= '0;
    end else begin
      if (dp.MDRin) mdr_q <= dp.Read ? dp.Mdatain : w_bus;
      if (dp.R1in)  r1_q  <= w_bus;
      if (dp.R2in)  r2_q  <= w_bus;
      if (dp.R3in)  r3_q  <= w_bus;
      if (dp.IRin)  ir_q  <= w_bus;
      if (dp.Yin)   y_q   <= w_bus;
      if (dp.HIin)  hi_q  <= w_bus;
      if (dp.AND)   z_q   <= w_alu;
    end
  end

  assign dp.BusMuxOut = w_bus;
  assign dp.R1_q      = r1_q;
  assign dp.R2_q      = r2_q;
  assign dp.R3_q      = r3_q;
  assign dp.IR_q      = ir_q;
  assign dp.HI_q      = hi_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_datapath.sv
// ============================================================================
// Module      : tb_cpu_datapath
// Description : Scoreboard bench for cpu_datapath driven by directed strobe vectors.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_datapath;

  localparam int c_BUS = 0;
  localparam int c_R1  = 1;
  localparam int c_R2  = 2;
  localparam int c_R3  = 3;
  localparam int c_IR  = 4;
  localparam int c_HI  = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    int          due;
  } chk_t;

  logic   clock = 1'b0;
  logic   clear = 1'b1;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_err = 0;
  chk_t   sb[$];

  cpu_datapath_if dpif ();

  cpu_datapath u_dut (
    .clock (clock),
    .clear (clear),
    .dp    (dpif.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      c_R1:    return dpif.R1_q;
      c_R2:    return dpif.R2_q;
      c_R3:    return dpif.R3_q;
      c_IR:    return dpif.IR_q;
      c_HI:    return dpif.HI_q;
      default: return dpif.BusMuxOut;
    endcase
  endfunction

  // Monitor: compare every queued expectation that falls due this cycle.
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        n_checks++;
        if (obs(sb[i].sel) !== sb[i].exp) begin
          n_err++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", sb[i].name, obs(sb[i].sel), sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        n_checks++;
        n_err++;
        $display("FAIL %s: never sampled (due cycle %0d)", sb[i].name, sb[i].due);
        sb.delete(i);
      end
    end
  end

  task automatic expect_val(input int sel, input logic [31:0] v, input int lat, input string nm);
    chk_t c;
    c.name = nm; c.sel = sel; c.exp = v; c.due = cyc + lat;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    dpif.Read = 0;  dpif.MDRin = 0; dpif.R1in = 0; dpif.R2in = 0; dpif.R3in = 0;
    dpif.IRin = 0;  dpif.Yin = 0;   dpif.HIin = 0; dpif.AND = 0;
    dpif.PCout = 0; dpif.MDRout = 0; dpif.R2out = 0; dpif.R3out = 0;
    dpif.Zlowout = 0; dpif.ZHighout = 0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    tick(); dpif.Mdatain = v; dpif.Read = 1; dpif.MDRin = 1;
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lo, input logic [31:0] hi, input string nm);
    load_mdr({28'b0, op});
    tick(); dpif.MDRout = 1; dpif.IRin = 1;
    load_mdr(a);
    tick(); dpif.MDRout = 1; dpif.Yin = 1;
    load_mdr(b);
    tick(); dpif.MDRout = 1; dpif.AND = 1;
    tick(); dpif.Zlowout = 1; dpif.R1in = 1;
    expect_val(c_BUS, lo, 0, {nm, "_zlo_bus"});
    expect_val(c_R1,  lo, 1, {nm, "_zlo_r1"});
    tick(); dpif.ZHighout = 1; dpif.HIin = 1;
    expect_val(c_BUS, hi, 0, {nm, "_zhi_bus"});
    expect_val(c_HI,  hi, 1, {nm, "_zhi_hi"});
  endtask

  initial begin
    dpif.Mdatain = '0;
    tick(); tick(); tick();
    clear = 0;
    expect_val(c_BUS, 32'h0, 0, "rst_bus");
    expect_val(c_R1,  32'h0, 0, "rst_r1");
    expect_val(c_R2,  32'h0, 0, "rst_r2");
    expect_val(c_R3,  32'h0, 0, "rst_r3");
    expect_val(c_IR,  32'h0, 0, "rst_ir");
    expect_val(c_HI,  32'h0, 0, "rst_hi");

    // Register loads through MDR
    load_mdr(32'h12);
    tick(); dpif.MDRout = 1; dpif.R2in = 1;
    expect_val(c_BUS, 32'h12, 0, "ld_bus");
    expect_val(c_R2,  32'h12, 1, "ld_r2");
    load_mdr(32'h01);
    tick(); dpif.MDRout = 1; dpif.R3in = 1;
    expect_val(c_R3, 32'h01, 1, "ld_r3");
    load_mdr(32'h18);
    tick(); dpif.MDRout = 1; dpif.R1in = 1;
    expect_val(c_R1, 32'h18, 1, "ld_r1");

    // SRA sequence using R2/R3 as operands
    load_mdr(32'h7);
    tick(); dpif.MDRout = 1; dpif.IRin = 1;
    expect_val(c_IR, 32'h7, 1, "sra_ir");
    tick(); dpif.R2out = 1; dpif.Yin = 1;
    tick(); dpif.R3out = 1; dpif.AND = 1;
    expect_val(c_BUS, 32'h1, 0, "sra_b_bus");
    tick(); dpif.Zlowout = 1; dpif.R1in = 1;
    expect_val(c_R1, 32'h9, 1, "sra_r1");
    tick(); dpif.ZHighout = 1; dpif.HIin = 1;
    expect_val(c_HI, 32'h0, 1, "sra_hi");

    // ALU opcode vectors
    alu(4'h7, 32'h8000_0010, 32'h4,         32'hF800_0001, 32'h0, "sra_sign");
    alu(4'h0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'h0, "and");
    alu(4'h1, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 32'h0, "or");
    alu(4'h2, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'h0, "add");
    alu(4'h3, 32'h5,         32'h7,         32'hFFFF_FFFE, 32'h0, "sub");
    alu(4'h5, 32'h8000_0000, 32'h21,        32'h4000_0000, 32'h0, "shr");
    alu(4'h6, 32'h3,         32'h4,         32'h0000_0030, 32'h0, "shl");
    alu(4'hF, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 32'h0, "op_f");
`ifdef DATAPATH_MUL_EN
    alu(4'h4, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFA, 32'hFFFF_FFFF, "mul");
`else
    alu(4'h4, 32'hFFFF_FFFE, 32'h3,         32'h0000_0002, 32'h0, "mul_as_and");
`endif

    // Bus priority and MDR-from-bus path (R2=0x12, R3=0x01)
    load_mdr(32'hAA);
    tick(); dpif.MDRout = 1; dpif.R2out = 1;
    expect_val(c_BUS, 32'hAA, 0, "pri_mdr_r2");
    tick(); dpif.PCout = 1; dpif.MDRout = 1;
    expect_val(c_BUS, 32'h0, 0, "pri_pc_mdr");
    tick(); dpif.R2out = 1; dpif.R3out = 1;
    expect_val(c_BUS, 32'h12, 0, "pri_r2_r3");
    tick(); dpif.R3out = 1; dpif.Zlowout = 1;
    expect_val(c_BUS, 32'h01, 0, "pri_r3_zlo");
    tick();
    expect_val(c_BUS, 32'h0, 0, "idle_bus");
    tick(); dpif.R3out = 1; dpif.MDRin = 1; dpif.Read = 0;
    tick(); dpif.MDRout = 1;
    expect_val(c_BUS, 32'h01, 0, "mdr_from_bus");

    // Two in-enables share one bus value
    load_mdr(32'h5A5A_0003);
    tick(); dpif.MDRout = 1; dpif.R2in = 1; dpif.R3in = 1;
    expect_val(c_R2, 32'h5A5A_0003, 1, "dual_r2");
    expect_val(c_R3, 32'h5A5A_0003, 1, "dual_r3");

    // Clear overrides a concurrent load
    load_mdr(32'h18);
    tick(); dpif.MDRout = 1; dpif.R1in = 1;
    expect_val(c_R1, 32'h18, 1, "pre_clr_r1");
    tick(); clear = 1; dpif.MDRout = 1; dpif.R1in = 1;
    tick(); clear = 0;
    expect_val(c_R1, 32'h0, 0, "clr_r1");
    expect_val(c_R2, 32'h0, 0, "clr_r2");
    expect_val(c_R3, 32'h0, 0, "clr_r3");
    expect_val(c_IR, 32'h0, 0, "clr_ir");
    expect_val(c_HI, 32'h0, 0, "clr_hi");
    dpif.MDRout = 1;
    expect_val(c_BUS, 32'h0, 0, "clr_mdr");
    tick(); dpif.Zlowout = 1;
    expect_val(c_BUS, 32'h0, 0, "clr_zlo");
    tick(); dpif.ZHighout = 1;
    expect_val(c_BUS, 32'h0, 0, "clr_zhi");

    repeat (4) tick();
    while (sb.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: pending at end of run, expected 0x%08h", sb[0].name, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
